morse_tx_engine: RTL and testbench

//  Parametrised Morse keyer: accepts one letter per valid/ready handshake as (code, len) and drives a

---
 rtl/morse_tx_engine_pkg.sv | 35 +++
 rtl/morse_tx_engine_unit_timer.sv | 36 +++
 rtl/morse_tx_engine.sv | 154 +++++++++++++++
 tb/tb_morse_tx_engine.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/morse_tx_engine_pkg.sv
// Shared types and constants for the Morse keyer: FSM states, default timing,
// and the A..Z letter table used by letter sources feeding the engine.
package morse_tx_engine_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMark,
        StEspace,
        StLgap,
        StWgap
    } state_e;

    localparam int unsigned DefUnitCycles     = 25_000_000;
    localparam int unsigned DefMaxLen         = 8;
    localparam int unsigned DefDashUnits      = 3;
    localparam int unsigned DefLetterGapUnits = 3;
    localparam int unsigned DefWordGapUnits   = 7;

    // code bit[len-1] is sent first; 1 = dash, 0 = dot
    typedef struct packed {
        logic [3:0] code;
        logic [2:0] len;
    } letter_t;

    localparam letter_t LetterTable [26] = '{
        '{4'b0001, 3'd2}, '{4'b1000, 3'd4}, '{4'b1010, 3'd4}, '{4'b0100, 3'd3},
        '{4'b0000, 3'd1}, '{4'b0010, 3'd4}, '{4'b0110, 3'd3}, '{4'b0000, 3'd4},
        '{4'b0000, 3'd2}, '{4'b0111, 3'd4}, '{4'b0101, 3'd3}, '{4'b0100, 3'd4},
        '{4'b0011, 3'd2}, '{4'b0010, 3'd2}, '{4'b0111, 3'd3}, '{4'b0110, 3'd4},
        '{4'b1101, 3'd4}, '{4'b0010, 3'd3}, '{4'b0000, 3'd3}, '{4'b0001, 3'd1},
        '{4'b0001, 3'd3}, '{4'b0001, 3'd4}, '{4'b0011, 3'd3}, '{4'b1001, 3'd4},
        '{4'b1011, 3'd4}, '{4'b1100, 3'd4}
    };

endpackage

// File: rtl/morse_tx_engine_unit_timer.sv
// Unit prescaler: counts UNIT_CYCLES clocks and emits a 1-cycle tick at the end
// of each unit. A synchronous restart aligns the next unit to the following edge.
module morse_tx_engine_unit_timer #(
    parameter int unsigned UNIT_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic unit_tick_o
);

    localparam int unsigned CntW = $clog2(UNIT_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(UNIT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: wrap at the last cycle of a unit, clear on restart.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || (cnt_q == CntLast)) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign unit_tick_o = !restart_i && (cnt_q == CntLast);

endmodule

// File: rtl/morse_tx_engine.sv
// Morse keyer: takes one letter per valid/ready handshake and keys morse_out
// with dot/dash/gap timing counted in units of UNIT_CYCLES clocks.
module morse_tx_engine
    import morse_tx_engine_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES      = DefUnitCycles,
    parameter int unsigned MAX_LEN          = DefMaxLen,
    parameter int unsigned DASH_UNITS       = DefDashUnits,
    parameter int unsigned LETTER_GAP_UNITS = DefLetterGapUnits,
    parameter int unsigned WORD_GAP_UNITS   = DefWordGapUnits
) (
    input  logic                             CLOCK_50,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [MAX_LEN-1:0]               in_code,
    input  logic [$clog2(MAX_LEN+1)-1:0]     in_len,
    input  logic                             abort,
    output logic                             morse_out,
    output logic                             busy,
    output logic                             done
);

    localparam int unsigned LenW     = $clog2(MAX_LEN + 1);
    localparam int unsigned IdxW     = $clog2(MAX_LEN);
    localparam int unsigned MaxGap   = (LETTER_GAP_UNITS > WORD_GAP_UNITS) ?
                                       LETTER_GAP_UNITS : WORD_GAP_UNITS;
    localparam int unsigned MaxUnits = (DASH_UNITS > MaxGap) ? DASH_UNITS : MaxGap;
    localparam int unsigned UnitsW   = $clog2(MaxUnits + 1);

    localparam logic [LenW-1:0]   MaxLenL    = LenW'(MAX_LEN);
    localparam logic [UnitsW-1:0] OneL       = UnitsW'(1);
    localparam logic [UnitsW-1:0] DashL      = UnitsW'(DASH_UNITS);
    localparam logic [UnitsW-1:0] LetterGapL = UnitsW'(LETTER_GAP_UNITS);
    localparam logic [UnitsW-1:0] WordGapL   = UnitsW'(WORD_GAP_UNITS);

    state_e              state_q, state_d;
    logic [MAX_LEN-1:0]  code_q, code_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [UnitsW-1:0]   units_q, units_d;
    logic                morse_out_q, morse_out_d;
    logic                done_q, done_d;

    logic [LenW-1:0]     len_clamped;
    logic [LenW-1:0]     len_m1;
    logic                unit_tick;

    assign in_ready  = (state_q == StIdle);
    assign busy      = !in_ready;
    assign morse_out = morse_out_q;
    assign done      = done_q;

    // Held in restart while idle so the first unit after accept is a full unit.
    morse_tx_engine_unit_timer #(
        .UNIT_CYCLES (UNIT_CYCLES)
    ) u_unit_timer (
        .clk_i       (CLOCK_50),
        .rst_i       (reset),
        .restart_i   (in_ready || abort),
        .unit_tick_o (unit_tick)
    );

    // Next-state: accept, element sequencing and unit countdown; abort wins.
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        idx_d       = idx_q;
        units_d     = units_q;
        morse_out_d = morse_out_q;
        done_d      = 1'b0;
        len_clamped = (in_len > MaxLenL) ? MaxLenL : in_len;
        len_m1      = len_clamped - LenW'(1);

        if (abort) begin
            if (state_q != StIdle) begin
                state_d     = StIdle;
                morse_out_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        code_d = in_code;
                        if (len_clamped == '0) begin
                            state_d = StWgap;
                            units_d = WordGapL;
                        end else begin
                            state_d     = StMark;
                            idx_d       = len_m1[IdxW-1:0];
                            units_d     = in_code[len_m1[IdxW-1:0]] ? DashL : OneL;
                            morse_out_d = 1'b1;
                        end
                    end
                end
                StMark: begin
                    if (unit_tick) begin
                        if (units_q == OneL) begin
                            morse_out_d = 1'b0;
                            if (idx_q == '0) begin
                                state_d = StLgap;
                                units_d = LetterGapL;
                            end else begin
                                state_d = StEspace;
                                units_d = OneL;
                                idx_d   = idx_q - 1'b1;
                            end
                        end else begin
                            units_d = units_q - OneL;
                        end
                    end
                end
                // Intra-letter gap is always exactly one unit.
                StEspace: begin
                    if (unit_tick) begin
                        state_d     = StMark;
                        units_d     = code_q[idx_q] ? DashL : OneL;
                        morse_out_d = 1'b1;
                    end
                end
                StLgap, StWgap: begin
                    if (unit_tick) begin
                        if (units_q == OneL) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            units_d = units_q - OneL;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            code_q      <= '0;
            idx_q       <= '0;
            units_q     <= '0;
            morse_out_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            idx_q       <= idx_d;
            units_q     <= units_d;
            morse_out_q <= morse_out_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_morse_tx_engine.sv
// Bench for morse_tx_engine: directed letters plus a randomized letter stream,
// compared cycle by cycle against a waveform built from the Morse timing rules.
module tb_morse_tx_engine;
    import morse_tx_engine_pkg::*;

    localparam int unsigned U  = 4;
    localparam int unsigned ML = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_code;
    logic [3:0] in_len;
    logic       abort;
    logic       morse_out;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    bit wave_q[$];

    always #5 clk = ~clk;

    morse_tx_engine #(
        .UNIT_CYCLES (U),
        .MAX_LEN     (ML)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_len    (in_len),
        .abort     (abort),
        .morse_out (morse_out),
        .busy      (busy),
        .done      (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected keyed waveform (one bit per cycle after accept), excluding the done cycle.
    function automatic void build_wave(input logic [7:0] code, input logic [3:0] len);
        int n;
        int mark;
        int gap;
        wave_q.delete();
        n = (int'(len) > ML) ? ML : int'(len);
        if (n == 0) begin
            for (int c = 0; c < 7 * U; c++) wave_q.push_back(1'b0);
        end
        for (int e = n - 1; e >= 0; e--) begin
            mark = code[e] ? 3 : 1;
            gap  = (e == 0) ? 3 : 1;
            for (int c = 0; c < mark * U; c++) wave_q.push_back(1'b1);
            for (int c = 0; c < gap * U; c++) wave_q.push_back(1'b0);
        end
    endfunction

    // Caller has already offered the letter at a negedge with in_ready high.
    task automatic run_letter(input logic [7:0] code, input logic [3:0] len, input bit scramble,
                              input bit hold, input logic [7:0] hcode, input logic [3:0] hlen);
        build_wave(code, len);
        for (int i = 0; i < wave_q.size(); i++) begin
            @(negedge clk);
            if (hold) begin
                in_valid = 1'b1;
                in_code  = hcode;
                in_len   = hlen;
            end else begin
                in_valid = 1'b0;
                if (scramble) begin
                    in_code = 8'($urandom);
                    in_len  = 4'($urandom_range(0, 15));
                end
            end
            check_eq("out", 32'(morse_out), 32'(wave_q[i]));
            check_eq("busy", 32'(busy), 32'd1);
            check_eq("done_lo", 32'(done), 32'd0);
        end
        @(negedge clk);
        check_eq("done", 32'(done), 32'd1);
        check_eq("ready_at_done", 32'(in_ready), 32'd1);
        check_eq("out_at_done", 32'(morse_out), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check_eq("idle_ready", 32'(in_ready), 32'd1);
            check_eq("idle_done", 32'(done), 32'd0);
            check_eq("idle_out", 32'(morse_out), 32'd0);
        end
    endtask

    task automatic offer(input logic [7:0] code, input logic [3:0] len);
        in_valid = 1'b1;
        in_code  = code;
        in_len   = len;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] code;
        logic [3:0] len;
        logic [7:0] ncode;
        logic [3:0] nlen;
        bit         b2b;
        bit         scr;

        rst = 1'b0; in_valid = 1'b0; abort = 1'b0; in_code = '0; in_len = '0;
        #1 rst = 1'b1;
        #1;
        check_eq("rst_ready", 32'(in_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_out", 32'(morse_out), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // 'A'
        offer(8'b01, 4'd2);
        run_letter(8'b01, 4'd2, 1'b0, 1'b0, 8'd0, 4'd0);
        idle(1);

        // 'E' with 'T' held valid throughout, then 'T' back to back
        offer(8'b0, 4'd1);
        run_letter(8'b0, 4'd1, 1'b0, 1'b1, 8'b1, 4'd1);
        run_letter(8'b1, 4'd1, 1'b0, 1'b0, 8'd0, 4'd0);
        idle(1);

        // Word space, then clamped over-length letter
        offer(8'h5A, 4'd0);
        run_letter(8'h5A, 4'd0, 1'b1, 1'b0, 8'd0, 4'd0);
        idle(1);
        offer(8'hA5, 4'd9);
        run_letter(8'hA5, 4'd9, 1'b0, 1'b0, 8'd0, 4'd0);
        idle(1);

        // Abort in the middle of the second dash of 'O'
        offer(8'b111, 4'd3);
        build_wave(8'b111, 4'd3);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check_eq("o_out", 32'(morse_out), 32'(wave_q[i]));
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_out", 32'(morse_out), 32'd0);
        check_eq("abort_ready", 32'(in_ready), 32'd1);
        check_eq("abort_done", 32'(done), 32'd0);
        idle(2);
        offer({4'b0, LetterTable[3].code}, {1'b0, LetterTable[3].len});
        run_letter({4'b0, LetterTable[3].code}, {1'b0, LetterTable[3].len},
                   1'b0, 1'b0, 8'd0, 4'd0);
        idle(1);

        // Abort together with a valid letter while idle: not accepted
        abort = 1'b1;
        offer(8'b1, 4'd1);
        @(negedge clk);
        abort = 1'b0;
        in_valid = 1'b0;
        check_eq("abort_idle_ready", 32'(in_ready), 32'd1);
        check_eq("abort_idle_out", 32'(morse_out), 32'd0);
        idle(2);

        // Async reset in the middle of the first dash of 'B'
        offer({4'b0, LetterTable[1].code}, {1'b0, LetterTable[1].len});
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check_eq("b_out", 32'(morse_out), 32'd1);
        end
        #2 rst = 1'b1;
        #1;
        check_eq("arst_out", 32'(morse_out), 32'd0);
        check_eq("arst_ready", 32'(in_ready), 32'd1);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // 'H': four dots
        offer({4'b0, LetterTable[7].code}, {1'b0, LetterTable[7].len});
        run_letter({4'b0, LetterTable[7].code}, {1'b0, LetterTable[7].len},
                   1'b0, 1'b0, 8'd0, 4'd0);
        idle(1);

        // Random letter stream with optional back-to-back and input scrambling
        code = 8'($urandom);
        len  = 4'($urandom_range(0, 9));
        offer(code, len);
        for (int n = 0; n < 20; n++) begin
            ncode = 8'($urandom);
            nlen  = 4'($urandom_range(0, 9));
            b2b   = 1'($urandom_range(0, 1));
            scr   = !b2b && 1'($urandom_range(0, 1));
            run_letter(code, len, scr, b2b, ncode, nlen);
            if (!b2b) begin
                idle($urandom_range(0, 2));
                offer(ncode, nlen);
            end
            code = ncode;
            len  = nlen;
        end
        run_letter(code, len, 1'b0, 1'b0, 8'd0, 4'd0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
